// File: rtl/pool2_row_sched.sv
// Row-sequenced 2x2 binary max-pool (NAND) scheduler; POOL2_CEIL_EN selects ceil mode with pad=1.
// Pooled row is registered 1 cycle after odd-row accept; in_ready is low while a pooled row awaits out_ready.
module pool2_row_sched #(
  parameter int IN_W = 25,
  parameter int IN_H = 25,
`ifdef POOL2_CEIL_EN
  localparam int OUT_W = (IN_W + 1) / 2,
  localparam int OUT_H = (IN_H + 1) / 2,
`else
  localparam int OUT_W = IN_W / 2,
  localparam int OUT_H = IN_H / 2,
`endif
  localparam int IDXW = $clog2(IN_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_row,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_row,
  output logic [IDXW-1:0]  out_row_idx,
  output logic             out_last,
  output logic             frame_done,
  output logic             busy
);

  typedef enum logic [1:0] {S_EVEN, S_ODD, S_OUT, S_TAIL} state_t;

  state_t           state_q, state_d;
  logic [IDXW-1:0]  row_cnt_q, row_cnt_d;
  logic [IN_W-1:0]  even_q, even_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_row_q, out_row_d;
  logic [IDXW-1:0]  out_row_idx_q, out_row_idx_d;
  logic             out_last_q, out_last_d;
  logic             frame_done_q, frame_done_d;
  logic             in_acc, out_acc;
  logic             unused_col;

  // Floor mode never looks at the last column of an odd-width row.
  assign unused_col = even_q[IN_W-1] ^ in_row[IN_W-1];

  function automatic logic [OUT_W-1:0] pool(input logic [IN_W-1:0] e, input logic [IN_W-1:0] o);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int j = 0; j < IN_W / 2; j++) begin
      r[j] = ~&{e[2*j], e[2*j+1], o[2*j], o[2*j+1]};
    end
`ifdef POOL2_CEIL_EN
    if (IN_W % 2 == 1) begin
      r[OUT_W-1] = ~(e[IN_W-1] & o[IN_W-1]);
    end
`endif
    return r;
  endfunction

  function automatic logic [IDXW-1:0] row_inc(input logic [IDXW-1:0] c);
    return (c == IDXW'(IN_H - 1)) ? '0 : c + 1'b1;
  endfunction

  assign in_ready = (state_q != S_OUT);
  assign in_acc   = in_valid && in_ready;
  assign out_acc  = out_valid_q && out_ready;

  always_comb begin
    state_d       = state_q;
    row_cnt_d     = row_cnt_q;
    even_d        = even_q;
    out_valid_d   = out_valid_q;
    out_row_d     = out_row_q;
    out_row_idx_d = out_row_idx_q;
    out_last_d    = out_last_q;
    frame_done_d  = 1'b0;

    case (state_q)
      S_EVEN: begin
        if (in_acc) begin
`ifdef POOL2_CEIL_EN
          if ((IN_H % 2 == 1) && (row_cnt_q == IDXW'(IN_H - 1))) begin
            // Unpaired final row pools against an all-ones pad row.
            out_valid_d   = 1'b1;
            out_row_d     = pool(in_row, '1);
            out_row_idx_d = row_cnt_q >> 1;
            out_last_d    = 1'b1;
            row_cnt_d     = '0;
            state_d       = S_OUT;
          end else begin
            even_d    = in_row;
            row_cnt_d = row_inc(row_cnt_q);
            state_d   = S_ODD;
          end
`else
          even_d    = in_row;
          row_cnt_d = row_inc(row_cnt_q);
          state_d   = S_ODD;
`endif
        end
      end
      S_ODD: begin
        if (in_acc) begin
          out_valid_d   = 1'b1;
          out_row_d     = pool(even_q, in_row);
          out_row_idx_d = row_cnt_q >> 1;
          out_last_d    = ((row_cnt_q >> 1) == IDXW'(OUT_H - 1));
          row_cnt_d     = row_inc(row_cnt_q);
          state_d       = S_OUT;
        end
      end
      S_OUT: begin
        if (out_acc) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          if (!out_last_q) begin
            state_d = S_EVEN;
          end
`ifndef POOL2_CEIL_EN
          else if (IN_H % 2 == 1) begin
            state_d = S_TAIL;
          end
`endif
          else begin
            state_d      = S_EVEN;
            row_cnt_d    = '0;
            frame_done_d = 1'b1;
          end
        end
      end
      S_TAIL: begin
        if (in_acc) begin
          state_d      = S_EVEN;
          row_cnt_d    = '0;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = S_EVEN;
    endcase

    // Abort wins over any handshake in the same cycle.
    if (flush) begin
      state_d      = S_EVEN;
      row_cnt_d    = '0;
      out_valid_d  = 1'b0;
      out_last_d   = 1'b0;
      frame_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_EVEN;
      row_cnt_q     <= '0;
      even_q        <= '0;
      out_valid_q   <= 1'b0;
      out_row_q     <= '0;
      out_row_idx_q <= '0;
      out_last_q    <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      row_cnt_q     <= row_cnt_d;
      even_q        <= even_d;
      out_valid_q   <= out_valid_d;
      out_row_q     <= out_row_d;
      out_row_idx_q <= out_row_idx_d;
      out_last_q    <= out_last_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_row     = out_row_q;
  assign out_row_idx = out_row_idx_q;
  assign out_last    = out_last_q;
  assign frame_done  = frame_done_q;
  assign busy        = (state_q != S_EVEN) || (row_cnt_q != '0);

endmodule

// File: tb/tb_pool2_row_sched.sv
// Directed scoreboard bench for pool2_row_sched (IN_W=25, IN_H=25).
`timescale 1ns/1ps
module tb_pool2_row_sched;
  localparam int IN_W = 25;
  localparam int IN_H = 25;
`ifdef POOL2_CEIL_EN
  localparam bit CEIL  = 1'b1;
  localparam int OUT_W = (IN_W + 1) / 2;
  localparam int OUT_H = (IN_H + 1) / 2;
  localparam logic [31:0] T2_EXP = 32'h1001;
`else
  localparam bit CEIL  = 1'b0;
  localparam int OUT_W = IN_W / 2;
  localparam int OUT_H = IN_H / 2;
  localparam logic [31:0] T2_EXP = 32'h001;
`endif
  localparam int IDXW = $clog2(IN_H);

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b1;
  logic [IN_W-1:0]  in_row = '0;
  logic             in_ready, out_valid, out_last, frame_done, busy;
  logic [OUT_W-1:0] out_row;
  logic [IDXW-1:0]  out_row_idx;

  pool2_row_sched #(.IN_W(IN_W), .IN_H(IN_H)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUT_W-1:0] row;
    logic [IDXW-1:0]  idx;
    logic             last;
    logic             eof;
  } exp_t;

  exp_t            sb[$];
  int              checks = 0;
  int              failures = 0;
  int              n_out = 0;
  int              fd_cnt = 0;
  logic            fd_hs = 1'b0;
  logic            fd_tail = 1'b0;
  int              m_cnt = 0;
  logic [IN_W-1:0] m_even = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: out-of-range pixels read as 1 (pad), so they never force a 1 out.
  function automatic logic [OUT_W-1:0] pool_ref(input logic [IN_W-1:0] e, input logic [IN_W-1:0] o);
    logic [OUT_W-1:0] r;
    logic a, b, c, d;
    r = '0;
    for (int j = 0; j < OUT_W; j++) begin
      a = e[2*j];
      c = o[2*j];
      b = (2*j + 1 < IN_W) ? e[(2*j+1) % IN_W] : 1'b1;
      d = (2*j + 1 < IN_W) ? o[(2*j+1) % IN_W] : 1'b1;
      r[j] = !(a && b && c && d);
    end
    return r;
  endfunction

  task automatic model_row(input logic [IN_W-1:0] r);
    exp_t e;
    if (m_cnt % 2 == 0) begin
      if (m_cnt == IN_H - 1 && CEIL) begin
        e.row = pool_ref(r, '1);
        e.idx = IDXW'(m_cnt / 2);
        e.last = 1'b1;
        e.eof = 1'b1;
        sb.push_back(e);
        m_cnt = 0;
      end else if (m_cnt == IN_H - 1) begin
        fd_tail = 1'b1;
        m_cnt = 0;
      end else begin
        m_even = r;
        m_cnt++;
      end
    end else begin
      e.row = pool_ref(m_even, r);
      e.idx = IDXW'(m_cnt / 2);
      e.last = (m_cnt / 2 == OUT_H - 1);
      e.eof = e.last && (CEIL || (IN_H % 2 == 0));
      sb.push_back(e);
      m_cnt = (m_cnt == IN_H - 1) ? 0 : m_cnt + 1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      chk("frame_done", frame_done, fd_hs | fd_tail);
      if (frame_done) fd_cnt++;
      fd_hs = 1'b0;
      fd_tail = 1'b0;
      if (out_valid && out_ready) begin
        chk("sb_has_expect", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("out_row", out_row, e.row);
          chk("out_row_idx", out_row_idx, e.idx);
          chk("out_last", out_last, e.last);
          fd_hs = e.eof;
          n_out++;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
    @(negedge clk);
  endtask

  task automatic send_row(input logic [IN_W-1:0] r);
    int t = 0;
    in_valid = 1'b1;
    in_row = r;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("in_accept_timeout", (t < 100), 1);
    @(posedge clk);
    model_row(r);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_rows(input int first, input int last, input int kind);
    logic [IN_W-1:0] r;
    for (int i = first; i <= last; i++) begin
      r = '1;
      if (kind == 1) r = IN_W'({$urandom, $urandom});
      send_row(r);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, f0;
    logic [IN_W-1:0] r;

    // Reset state
    idle(2);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_row_idx", out_row_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    idle(2);

    // All-ones frame, continuous out_ready
    n0 = n_out; f0 = fd_cnt;
    send_rows(0, IN_H - 1, 0);
    idle(4);
    chk("t1_out_count", n_out - n0, OUT_H);
    chk("t1_frame_done_count", fd_cnt - f0, 1);
    chk("t1_busy_after", busy, 0);
    chk("t1_sb_empty", sb.size(), 0);

    // row0 col0 = 0, row1 last col = 0
    r = '1; r[0] = 1'b0;
    send_row(r);
    r = '1; r[IN_W-1] = 1'b0;
    send_row(r);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_out_row", out_row, T2_EXP);
    chk("t2_out_row_idx", out_row_idx, 0);
    send_rows(2, IN_H - 1, 0);
    idle(4);
    chk("t2_sb_empty", sb.size(), 0);

    // Backpressure on the first pooled row, row 2 presented during the stall
    send_rows(0, 0, 1);
    set_ready(1'b0);
    send_rows(1, 1, 1);
    r = IN_W'({$urandom, $urandom});
    in_valid = 1'b1;
    in_row = r;
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_row", out_row, sb[0].row);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    set_ready(1'b1);
    send_row(r);
    send_rows(3, IN_H - 1, 1);
    idle(4);
    chk("bp_sb_empty", sb.size(), 0);

    // Flush the cycle after row 7 is accepted
    f0 = fd_cnt;
    send_rows(0, 7, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    sb.delete();
    m_cnt = 0;
    chk("fl_busy", busy, 0);
    chk("fl_out_valid", out_valid, 0);
    n0 = n_out;
    send_rows(0, 1, 1);
    chk("fl_first_idx", out_row_idx, 0);
    send_rows(2, IN_H - 1, 1);
    idle(4);
    chk("fl_out_count", n_out - n0, OUT_H);
    chk("fl_frame_done_count", fd_cnt - f0, 1);

    // Async reset while pooled row idx 4 is held
    send_rows(0, 8, 1);
    set_ready(1'b0);
    send_rows(9, 9, 1);
    chk("ar_out_valid_before", out_valid, 1);
    chk("ar_out_row_idx_before", out_row_idx, sb[0].idx);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid_now", out_valid, 0);
    chk("ar_busy_now", busy, 0);
    sb.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    n0 = n_out;
    send_rows(0, IN_H - 1, 1);
    idle(4);
    chk("ar_out_count", n_out - n0, OUT_H);
    chk("ar_sb_empty", sb.size(), 0);

`ifdef POOL2_CEIL_EN
    // Ceil mode: final unpaired row with a zero in the last column
    send_rows(0, IN_H - 2, 0);
    idle(2);
    r = '1; r[IN_W-1] = 1'b0;
    send_row(r);
    chk("ceil_out_row", out_row, 32'h1000);
    chk("ceil_out_last", out_last, 1);
    idle(4);
    chk("ceil_sb_empty", sb.size(), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
